univ_shiftreg: RTL

Parametrised universal shift register; the next generation of the team's 16-bit load/right-shift register. Adds left shift, arithmetic right shift, both rotates, a serial output, and a multi-bit shift engine. The engine takes a shift amount and steps one bit per clock, with a busy/done handshake. It sits in datapaths that serialise words or perform sequential shift-by-N for simple ALUs.

---
 rtl/shiftreg_pkg.sv | 32 +++
 rtl/shift_step.sv | 61 ++++++
 rtl/univ_shiftreg.sv | 130 +++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shiftreg_pkg
//  Description : Shared types for the universal shift register: shift-mode
//                encodings, controller state encoding and a mode-validity
//                helper used by both the single-step and multi-step paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package shiftreg_pkg;

    localparam int c_MODE_W = 3;

    typedef enum logic [c_MODE_W-1:0] {
        MODE_SHR = 3'd0,
        MODE_SHL = 3'd1,
        MODE_ASR = 3'd2,
        MODE_ROR = 3'd3,
        MODE_ROL = 3'd4
    } mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Encodings above MODE_ROL are reserved and must leave the register alone.
    function automatic logic mode_is_valid(input logic [c_MODE_W-1:0] mode);
        return (mode <= MODE_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-step shifter. Computes the next
//                register value and the expelled bit for one step in the
//                selected mode.
//  Ports       : d      - current register value
//                s_in   - serial input bit (SHR/SHL fill)
//                mode   - shift mode
//                d_next - register value after one step
//                s_exp  - bit expelled by this step
//                valid  - mode is a real shift (reserved modes hold state)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]    d,
    input  logic                s_in,
    input  logic [c_MODE_W-1:0] mode,
    output logic [WIDTH-1:0]    d_next,
    output logic                s_exp,
    output logic                valid
);

    always_comb begin
        d_next = d;
        s_exp  = 1'b0;
        valid  = mode_is_valid(mode);
        case (mode)
            MODE_SHR: begin
                d_next = {s_in, d[WIDTH-1:1]};
                s_exp  = d[0];
            end
            MODE_SHL: begin
                d_next = {d[WIDTH-2:0], s_in};
                s_exp  = d[WIDTH-1];
            end
            MODE_ASR: begin
                d_next = {d[WIDTH-1], d[WIDTH-1:1]};
                s_exp  = d[0];
            end
            MODE_ROR: begin
                d_next = {d[0], d[WIDTH-1:1]};
                s_exp  = d[0];
            end
            MODE_ROL: begin
                d_next = {d[WIDTH-2:0], d[WIDTH-1]};
                s_exp  = d[WIDTH-1];
            end
            default: begin
                d_next = d;
                s_exp  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/univ_shiftreg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shiftreg
//  Description : Parametrised universal shift register with parallel load,
//                five shift modes, serial output and a multi-bit shift
//                engine that performs one step per clock with busy/done.
//  Ports       : clk, rst_n (async, active-low), clr (sync clear)
//                ld/data_in     - parallel load
//                s_in           - serial input bit, sampled every step
//                mode/sft       - single-step shift in IDLE
//                start/amt      - multi-bit shift of amt steps
//                data_out/s_out - register contents / last expelled bit
//                busy/done      - multi-bit shift in progress / complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shiftreg
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                ld,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                s_in,
    input  logic [c_MODE_W-1:0] mode,
    input  logic                sft,
    input  logic                start,
    input  logic [AMT_W-1:0]    amt,
    output logic [WIDTH-1:0]    data_out,
    output logic                s_out,
    output logic                busy,
    output logic                done
);

    localparam logic [AMT_W-1:0] c_CNT_ONE = AMT_W'(1);

    state_e              r_state;
    logic [WIDTH-1:0]    r_data;
    logic                r_s_out;
    logic                r_done;
    logic [AMT_W-1:0]    r_cnt;
    logic [c_MODE_W-1:0] r_mode_q;

    logic [c_MODE_W-1:0] w_step_mode;
    logic [WIDTH-1:0]    w_step_data;
    logic                w_step_exp;
    logic                w_step_valid;

    // One shifter serves both paths: the latched mode while a multi-bit
    // shift runs, the live mode for single steps.
    assign w_step_mode = (r_state == RUN) ? r_mode_q : mode;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .d      (r_data),
        .s_in   (s_in),
        .mode   (w_step_mode),
        .d_next (w_step_data),
        .s_exp  (w_step_exp),
        .valid  (w_step_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_s_out  <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_mode_q <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_data  <= '0;
                        r_s_out <= 1'b0;
                    end else if (ld) begin
                        r_data <= data_in;
                    end else if (start) begin
                        if (amt == '0) begin
                            // Nothing to shift: complete immediately.
                            r_done <= 1'b1;
                        end else begin
                            r_mode_q <= mode;
                            r_cnt    <= amt;
                            r_state  <= RUN;
                        end
                    end else if (sft) begin
                        if (w_step_valid) begin
                            r_data  <= w_step_data;
                            r_s_out <= w_step_exp;
                        end
                    end
                end
                RUN: begin
                    if (clr) begin
                        // Abort without signalling completion.
                        r_data  <= '0;
                        r_s_out <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        if (w_step_valid) begin
                            r_data  <= w_step_data;
                            r_s_out <= w_step_exp;
                        end
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (r_cnt == c_CNT_ONE) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign s_out    = r_s_out;
    assign busy     = (r_state == RUN);
    assign done     = r_done;

endmodule
`default_nettype wire
